// File: rtl/cell_plot_arbiter.sv
// Round-robin owner of the VGA pixel-write port: grants one cell request at a
// time, scans the 8x8-board cell out pixel by pixel, then pulses done to the winner.

module cell_plot_req_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic          req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          upper_o
);
  // Requester sits at or above the rotation pointer: wins before any wrapped lane.
  assign upper_o = req_i && (LANE >= int'(ptr_i));
endmodule

module cell_plot_arbiter #(
  parameter int N_REQ = 3,
  parameter int CELL  = 14,
  parameter int X0    = 24,
  parameter int Y0    = 4
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [3*N_REQ-1:0] cell_x_i,
  input  logic [3*N_REQ-1:0] cell_y_i,
  input  logic [2*N_REQ-1:0] select_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               busy_o,
  output logic [7:0]         x_o,
  output logic [6:0]         y_o,
  output logic [2:0]         colour_o,
  output logic               plot_o
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(CELL - 1);

  localparam logic [2:0] C_FELT  = 3'b010;
  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_WHITE = 3'b111;
  localparam logic [2:0] C_CURS  = 3'b110;

  typedef struct packed {
    logic [2:0] cx;
    logic [2:0] cy;
    logic [1:0] sel;
  } cell_req_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t                       state_q;
  cell_req_t                    cur_q;
  logic      [IW-1:0]           ptr_q, win_q;
  logic      [CW-1:0]           i_q, j_q;
  logic      [N_REQ-1:0]        gnt_q, done_q;
  logic                         busy_q, plot_q;
  logic      [7:0]              x_q;
  logic      [6:0]              y_q;
  logic      [2:0]              colour_q;

  cell_req_t [N_REQ-1:0]        lane_req;
  logic      [N_REQ-1:0]        upper, pick, win_oh;
  logic      [IW-1:0]           win_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    cell_plot_req_lane #(.IW(IW), .LANE(g)) u_lane (
      .req_i   (req_i[g]),
      .ptr_i   (ptr_q),
      .upper_o (upper[g])
    );
    assign lane_req[g] = {cell_x_i[3*g +: 3], cell_y_i[3*g +: 3], select_i[2*g +: 2]};
  end

  // Lowest index among lanes at/above ptr; if none, lowest overall (wrap).
  always_comb begin
    pick    = (|upper) ? upper : req_i;
    win_idx = '0;
    win_oh  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pick[k]) begin
        win_idx   = IW'(k);
        win_oh    = '0;
        win_oh[k] = 1'b1;
      end
    end
  end

  logic       edge_i, edge_j, corner, border;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d;

  assign edge_i = (i_q == '0) || (i_q == LAST);
  assign edge_j = (j_q == '0) || (j_q == LAST);
  assign corner = edge_i && edge_j;
  assign border = edge_i || edge_j;
  assign x_d    = 8'(X0) + 8'(cur_q.cx) * 8'(CELL) + 8'(i_q);
  assign y_d    = 7'(Y0) + 7'(cur_q.cy) * 7'(CELL) + 7'(j_q);

  // Disk corners stay felt-green for a rounded look; cursor writes border only.
  always_comb begin
    colour_d = C_FELT;
    plot_d   = 1'b1;
    unique case (cur_q.sel)
      2'd0: colour_d = C_FELT;
      2'd1: colour_d = corner ? C_FELT : C_BLACK;
      2'd2: colour_d = corner ? C_FELT : C_WHITE;
      2'd3: begin
        colour_d = C_CURS;
        plot_d   = border;
      end
      default: colour_d = C_FELT;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      done_q <= '0;
      plot_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            cur_q   <= lane_req[win_idx];
            win_q   <= win_idx;
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          x_q      <= x_d;
          y_q      <= y_d;
          colour_q <= colour_d;
          plot_q   <= plot_d;
          if (i_q == LAST) begin
            i_q <= '0;
            if (j_q == LAST) begin
              j_q     <= '0;
              done_q  <= gnt_q;
              state_q <= S_DONE;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        S_DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign plot_o   = plot_q;
endmodule

// File: tb/tb_cell_plot_arbiter.sv
// Bench for cell_plot_arbiter: cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_cell_plot_arbiter;
  localparam int N = 3, CELL = 14, X0 = 24, Y0 = 4, NPIX = CELL * CELL;

  logic       clock = 1'b0, resetn = 1'b0;
  logic [2:0] req = '0;
  logic [8:0] cx = '0, cy = '0;
  logic [5:0] sel = '0;
  logic [2:0] gnt_o, done_o, colour_o;
  logic       busy_o, plot_o;
  logic [7:0] x_o;
  logic [6:0] y_o;

  cell_plot_arbiter #(.N_REQ(N), .CELL(CELL), .X0(X0), .Y0(Y0)) dut (
    .clock_i(clock), .resetn_i(resetn), .req_i(req), .cell_x_i(cx), .cell_y_i(cy),
    .select_i(sel), .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o), .x_o(x_o),
    .y_o(y_o), .colour_o(colour_o), .plot_o(plot_o));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_asrt = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Model: owner, cycles since grant, rotation pointer, latched cell.
  int m_own = -1, m_ptr = 0, m_cnt = 0, m_cx = 0, m_cy = 0, m_sel = 0;
  int plot_cnt, green_cnt, white_cnt, c110_cnt, border_cnt, xmin, xmax, ymin, ymax;
  int done_cnt [3];
  int done_cyc [3];
  int glog[$];
  int gnt_cyc = 0;
  logic [2:0] prev_gnt = '0;

  task automatic clear_stats();
    plot_cnt = 0; green_cnt = 0; white_cnt = 0; c110_cnt = 0; border_cnt = 0;
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
  endtask

  always @(negedge clock) begin : mon
    int p, pi, pj, ex, ey, k;
    logic cor, bor, ep, found;
    logic [2:0] eg, ed, ecol;
    if (!resetn) begin
      chk("rst_outputs", {gnt_o, done_o, busy_o, x_o, y_o, colour_o, plot_o}, 0);
      m_own = -1; m_ptr = 0; m_cnt = 0;
      prev_gnt = '0;
    end else begin
      eg = '0; ed = '0; ep = 1'b0; ecol = '0; ex = 0; ey = 0;
      if (m_own >= 0) begin
        eg[m_own] = 1'b1;
        if (m_cnt == NPIX + 1) ed = eg;
        if (m_cnt >= 2) begin
          p = m_cnt - 2; pi = p % CELL; pj = p / CELL;
          cor = (pi == 0 || pi == CELL-1) && (pj == 0 || pj == CELL-1);
          bor = (pi == 0 || pi == CELL-1) || (pj == 0 || pj == CELL-1);
          ex = X0 + m_cx * CELL + pi;
          ey = Y0 + m_cy * CELL + pj;
          ep = (m_sel == 3) ? bor : 1'b1;
          case (m_sel)
            0: ecol = 3'b010;
            1: ecol = cor ? 3'b010 : 3'b000;
            2: ecol = cor ? 3'b010 : 3'b111;
            default: ecol = 3'b110;
          endcase
        end
      end
      chk("gnt", gnt_o, eg);
      chk("busy", busy_o, (m_own >= 0));
      chk("done", done_o, ed);
      chk("plot", plot_o, ep);
      if (ep) begin
        chk("x", x_o, ex);
        chk("y", y_o, ey);
        chk("colour", colour_o, ecol);
      end
      if (plot_o) begin
        plot_cnt++;
        if (colour_o == 3'b010) green_cnt++;
        if (colour_o == 3'b111) white_cnt++;
        if (colour_o == 3'b110) c110_cnt++;
        if (x_o >= 24 && x_o <= 37 && y_o >= 4 && y_o <= 17 &&
            (x_o == 24 || x_o == 37 || y_o == 4 || y_o == 17)) border_cnt++;
        if (int'(x_o) < xmin) xmin = x_o;
        if (int'(x_o) > xmax) xmax = x_o;
        if (int'(y_o) < ymin) ymin = y_o;
        if (int'(y_o) > ymax) ymax = y_o;
      end
      for (int q = 0; q < N; q++) if (done_o[q]) begin done_cnt[q]++; done_cyc[q] = cyc; end
      if (gnt_o != 0 && prev_gnt == 0) begin
        for (int q = 0; q < N; q++) if (gnt_o[q]) glog.push_back(q);
        gnt_cyc = cyc;
      end
      prev_gnt = gnt_o;
      // Advance model to the next cycle using the request levels present now.
      if (m_own < 0) begin
        found = 1'b0;
        for (int s = 0; s < N; s++) begin
          k = (m_ptr + s) % N;
          if (!found && req[k]) begin found = 1'b1; m_own = k; end
        end
        if (found) begin
          m_cx = cx[3*m_own +: 3]; m_cy = cy[3*m_own +: 3]; m_sel = sel[2*m_own +: 2];
          m_cnt = 1;
        end
      end else if (m_cnt == NPIX + 1) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic set_cell(input int k, input int x, input int y, input int s);
    cx[3*k +: 3] = 3'(x); cy[3*k +: 3] = 3'(y); sel[2*k +: 2] = 2'(s);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_done(input int k, input int maxc);
    int start, c;
    start = done_cnt[k]; c = 0;
    while (done_cnt[k] == start && c < maxc) begin @(posedge clock); c++; end
    chk("done_timeout", done_cnt[k] - start, 1);
  endtask

  task automatic run_serve(input int maxc);
    logic [2:0] drop;
    drop = '0;
    for (int c = 0; c < maxc && req != 0; c++) begin
      @(posedge clock); #1;
      req  = req & ~drop;
      drop = done_o;
    end
    chk("serve_timeout", req, 0);
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (busy_o && c < maxc) begin @(posedge clock); c++; end
    chk("idle_timeout", busy_o, 0);
  endtask

  int t0, dc0, dc1, t_req2, max_wait, w, rearm;
  logic drop2, g2_prev;

  initial begin
    for (int q = 0; q < N; q++) begin done_cnt[q] = 0; done_cyc[q] = 0; end
    clear_stats();
    #1 chk("reset_gnt_busy", {gnt_o, busy_o, plot_o}, 0);
    do_reset();

    // Single white disk at cell (2,5) from requester 1.
    clear_stats(); glog.delete();
    @(posedge clock); #1;
    set_cell(1, 2, 5, 2); req = 3'b010; t0 = cyc;
    wait_done(1, 400);
    #1 req = 3'b000;
    repeat (3) @(posedge clock);
    chk("disk_gnt_cycle", gnt_cyc - t0, 1);
    chk("disk_done_cycle", done_cyc[1] - t0, 197);
    chk("disk_strobes", plot_cnt, 196);
    chk("disk_corners", green_cnt, 4);
    chk("disk_white", white_cnt, 192);
    chk("disk_xmin", xmin, 52); chk("disk_xmax", xmax, 65);
    chk("disk_ymin", ymin, 74); chk("disk_ymax", ymax, 87);

    // Cursor outline at (0,0) from requester 0.
    clear_stats();
    @(posedge clock); #1;
    set_cell(0, 0, 0, 3); req = 3'b001;
    wait_done(0, 400);
    #1 req = 3'b000;
    repeat (3) @(posedge clock);
    chk("cursor_strobes", plot_cnt, 52);
    chk("cursor_colour", c110_cnt, 52);
    chk("cursor_border", border_cnt, 52);

    // Reset at pixel 100 of a black disk; ptr is 1 beforehand.
    clear_stats();
    @(posedge clock); #1;
    set_cell(0, 3, 3, 1); req = 3'b001;
    for (int c = 0; c < 300 && plot_cnt < 100; c++) @(posedge clock);
    chk("abort_reached_px100", plot_cnt >= 100, 1);
    dc0 = done_cnt[0];
    #3 resetn = 1'b0; req = 3'b000;
    #1 chk("async_rst_outputs", {gnt_o, done_o, busy_o, x_o, y_o, colour_o, plot_o}, 0);
    repeat (3) @(posedge clock);
    chk("abort_no_done", done_cnt[0] - dc0, 0);
    set_cell(1, 5, 2, 0); glog.delete();
    #1 resetn = 1'b1; req = 3'b011;
    run_serve(700);
    wait_idle(300);
    chk("post_rst_n", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("post_rst_first", glog[0], 0);
      chk("post_rst_second", glog[1], 1);
    end
    chk("post_rst_done0", done_cnt[0] - dc0, 1);

    // Simultaneous requests from reset.
    set_cell(0, 1, 2, 1); set_cell(1, 6, 0, 2); set_cell(2, 7, 7, 3);
    @(posedge clock); #1 resetn = 1'b0; req = 3'b111;
    repeat (2) @(posedge clock);
    glog.delete();
    #1 resetn = 1'b1; t0 = cyc;
    run_serve(900);
    wait_idle(300);
    chk("sim_n", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("sim_order0", glog[0], 0); chk("sim_order1", glog[1], 1); chk("sim_order2", glog[2], 2);
    end
    chk("sim_done0", done_cyc[0] - t0, 197);
    chk("sim_done1", done_cyc[1] - t0, 395);
    chk("sim_done2", done_cyc[2] - t0, 593);

    // Fairness: requester 0 permanent, requester 2 re-pulsed after each service.
    set_cell(0, 4, 0, 1); set_cell(2, 6, 7, 2);
    do_reset();
    req = 3'b101; t_req2 = cyc; glog.delete();
    max_wait = 0; drop2 = 1'b0; g2_prev = 1'b0; rearm = 0;
    for (int c = 0; c < 1200 && glog.size() < 4; c++) begin
      @(posedge clock); #1;
      if (drop2) begin req[2] = 1'b0; drop2 = 1'b0; rearm = 20; end
      else if (rearm > 0) begin rearm--; if (rearm == 0) begin req[2] = 1'b1; t_req2 = cyc; end end
      if (done_o[2]) drop2 = 1'b1;
      if (gnt_o[2] && !g2_prev) begin w = cyc - t_req2; if (w > max_wait) max_wait = w; end
      g2_prev = gnt_o[2];
    end
    req = 3'b000;
    wait_idle(300);
    chk("fair_n", glog.size(), 4);
    if (glog.size() >= 4) begin
      chk("fair_g0", glog[0], 0); chk("fair_g1", glog[1], 2);
      chk("fair_g2", glog[2], 0); chk("fair_g3", glog[3], 2);
    end
    chk("fair_wait_le_cell", max_wait <= NPIX + 3, 1);

    // Withdrawn request while requester 0 draws.
    clear_stats(); glog.delete(); dc1 = done_cnt[1];
    @(posedge clock); #1;
    set_cell(0, 1, 1, 0); req = 3'b001;
    repeat (10) @(posedge clock);
    #1 set_cell(1, 7, 7, 2); req[1] = 1'b1;
    @(posedge clock); #1 req[1] = 1'b0;
    wait_done(0, 400);
    #1 req[0] = 1'b0;
    repeat (5) @(posedge clock);
    chk("wd_grants", glog.size(), 1);
    chk("wd_no_done1", done_cnt[1] - dc1, 0);
    chk("wd_green", green_cnt, 196);

    // Requester 1 drops req mid-draw of its own cell.
    clear_stats();
    #1 req[1] = 1'b1;
    for (int c = 0; c < 10 && !gnt_o[1]; c++) @(posedge clock);
    chk("wd2_granted", gnt_o[1], 1);
    repeat (50) @(posedge clock);
    #1 req[1] = 1'b0;
    wait_done(1, 300);
    repeat (3) @(posedge clock);
    chk("wd2_strobes", plot_cnt, 196);
    chk("wd2_done", done_cnt[1] - dc1, 1);
    chk("wd2_xmin", xmin, 122); chk("wd2_xmax", xmax, 135);
    chk("wd2_ymin", ymin, 102); chk("wd2_ymax", ymax, 115);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
